// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------------------------
// updown_mod_counter
//   Synchronous up/down modulo counter, range 0..MODULUS-1, single clock domain.
//   Supports count enable, direction, wrap or saturate at the limits, synchronous clear,
//   clamped parallel load, and a combinational terminal count for cascading.
//
// Ports
//   i_clk        sole clock, all registers update on its rising edge
//   i_rst        synchronous active-high reset
//   i_en         count enable
//   i_up_dn      direction: 1 = up, 0 = down
//   i_sat_mode   0 = wrap at the limits, 1 = saturate at the limits
//   i_clr        synchronous clear to zero
//   i_load       synchronous parallel load (clamped to MODULUS-1)
//   i_load_val   value for load
//   o_q          current count (registered)
//   o_tc         terminal count, combinational from q/en/up_dn; drives a downstream en
//   o_wrap_pulse registered one-cycle pulse, high while the wrapped value is on o_q
//   o_sat_hit    registered sticky flag: a count was blocked at a limit
// ---------------------------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_dn,
  input  logic             i_sat_mode,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap_pulse,
  output logic             o_sat_hit
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap_pulse;
  logic             r_sat_hit;

  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_sat_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_at_max       = (r_q == MaxVal);
  assign w_at_zero      = (r_q == '0);
  // Out-of-range load values clamp so q can never hold a code above MaxVal.
  assign w_load_clamped = (i_load_val > MaxVal) ? MaxVal : i_load_val;

  // Priority below reset: clr > load > en. Wrap pulse defaults low so it lasts one cycle.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    w_sat_next  = r_sat_hit;
    if (i_clr) begin
      w_q_next   = '0;
      w_sat_next = 1'b0;
    end else if (i_load) begin
      w_q_next   = w_load_clamped;
      w_sat_next = 1'b0;
    end else if (i_en) begin
      if (i_up_dn) begin
        if (!w_at_max) begin
          w_q_next = r_q + WIDTH'(1);
        end else if (i_sat_mode) begin
          w_sat_next = 1'b1;
        end else begin
          w_q_next    = '0;
          w_wrap_next = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_q_next = r_q - WIDTH'(1);
        end else if (i_sat_mode) begin
          w_sat_next = 1'b1;
        end else begin
          w_q_next    = MaxVal;
          w_wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q          <= '0;
      r_wrap_pulse <= 1'b0;
      r_sat_hit    <= 1'b0;
    end else begin
      r_q          <= w_q_next;
      r_wrap_pulse <= w_wrap_next;
      r_sat_hit    <= w_sat_next;
    end
  end

  assign o_q          = r_q;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_sat_hit    = r_sat_hit;
  // Zero-latency terminal count so a cascaded stage advances on the same edge.
  assign o_tc         = i_en & ((i_up_dn & w_at_max) | (~i_up_dn & w_at_zero));

endmodule

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------------------------
// tb_updown_mod_counter
//   Bench for updown_mod_counter: a MODULUS=10 instance, a MODULUS=16 instance sharing its
//   inputs, and two MODULUS=10 instances cascaded as a two-digit decimal counter.
//   Expected values come from an integer reference model of the counting rules.
// ---------------------------------------------------------------------------------------------
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       sat_mode = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       c_en = 1'b0;

  logic [3:0] q, q16, lo_q, hi_q;
  logic       tc, tc16, lo_tc, hi_tc;
  logic       wrap, wrap16, lo_wrap, hi_wrap;
  logic       sat, sat16, lo_sat, hi_sat;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  int m_q = 0, m_w = 0, m_s = 0;
  int m16_q = 0, m16_w = 0, m16_s = 0;
  int c_cnt = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_sat_mode(sat_mode),
    .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .o_q(q), .o_tc(tc), .o_wrap_pulse(wrap), .o_sat_hit(sat)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_dn(up_dn), .i_sat_mode(sat_mode),
    .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .o_q(q16), .o_tc(tc16), .o_wrap_pulse(wrap16), .o_sat_hit(sat16)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .i_clk(clk), .i_rst(rst), .i_en(c_en), .i_up_dn(1'b1), .i_sat_mode(1'b0),
    .i_clr(1'b0), .i_load(1'b0), .i_load_val(4'd0),
    .o_q(lo_q), .o_tc(lo_tc), .o_wrap_pulse(lo_wrap), .o_sat_hit(lo_sat)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_en(lo_tc), .i_up_dn(1'b1), .i_sat_mode(1'b0),
    .i_clr(1'b0), .i_load(1'b0), .i_load_val(4'd0),
    .o_q(hi_q), .o_tc(hi_tc), .o_wrap_pulse(hi_wrap), .o_sat_hit(hi_sat)
  );

  // Counting rules applied to integer state for a counter with maximum value mx.
  task automatic model_next(input int mx, input int q_i, input int s_i,
                            output int q_o, output int w_o, output int s_o);
    q_o = q_i; w_o = 0; s_o = s_i;
    if (rst || clr) begin
      q_o = 0; s_o = 0;
    end else if (load) begin
      q_o = (int'(load_val) > mx) ? mx : int'(load_val);
      s_o = 0;
    end else if (en) begin
      if (up_dn) begin
        if (q_i < mx) q_o = q_i + 1;
        else if (sat_mode) s_o = 1;
        else begin q_o = 0; w_o = 1; end
      end else begin
        if (q_i > 0) q_o = q_i - 1;
        else if (sat_mode) s_o = 1;
        else begin q_o = mx; w_o = 1; end
      end
    end
  endtask

  function automatic bit model_tc(input int mx, input int qv);
    return en && ((up_dn && qv == mx) || (!up_dn && qv == 0));
  endfunction

  // Advance one clock: update every model on the edge, then sample 1 time unit later.
  task automatic step();
    int nq, nw, ns;
    @(posedge clk);
    model_next(9, m_q, m_s, nq, nw, ns);
    m_q = nq; m_w = nw; m_s = ns;
    model_next(15, m16_q, m16_s, nq, nw, ns);
    m16_q = nq; m16_w = nw; m16_s = ns;
    if (rst) c_cnt = 0;
    else if (c_en) c_cnt = (c_cnt + 1) % 100;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; en = 0; up_dn = 1; sat_mode = 0; clr = 0; load = 0; load_val = 0; c_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; en = 1;
    step(); step();
    n_cmp++; if (q !== 4'd0) begin n_bad++; $display("FAIL reset_q got %0d want 0", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", sat); end
    n_cmp++;
    if ({hi_q, lo_q} !== 8'h00) begin
      n_bad++; $display("FAIL reset_cascade got %h want 00", {hi_q, lo_q});
    end
  endtask

  task automatic test_count_up();
    int nwrap = 0;
    idle_inputs();
    rst = 1; step(); step();
    rst = 0; en = 1; up_dn = 1; sat_mode = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_cmp++;
      if (tc !== model_tc(9, m_q)) begin
        n_bad++; $display("FAIL up_tc q=%0d got %b want %b", q, tc, model_tc(9, m_q));
      end
      step();
      n_cmp++;
      if (q !== 4'(m_q) || wrap !== 1'(m_w)) begin
        n_bad++; $display("FAIL up_q got q=%0d w=%b want q=%0d w=%0d", q, wrap, m_q, m_w);
      end
      if (wrap) nwrap++;
    end
    n_cmp++;
    if (nwrap != 1) begin n_bad++; $display("FAIL up_wrap_count got %0d want 1", nwrap); end
  endtask

  task automatic test_count_down();
    idle_inputs();
    load = 1; load_val = 4'd2; step();
    load = 0; en = 1; up_dn = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (tc !== model_tc(9, m_q)) begin
        n_bad++; $display("FAIL down_tc q=%0d got %b want %b", q, tc, model_tc(9, m_q));
      end
      step();
      n_cmp++;
      if (q !== 4'(m_q) || wrap !== 1'(m_w)) begin
        n_bad++; $display("FAIL down_q got q=%0d w=%b want q=%0d w=%0d", q, wrap, m_q, m_w);
      end
    end
    n_cmp++;
    if (q !== 4'd8) begin n_bad++; $display("FAIL down_end got %0d want 8", q); end
  endtask

  task automatic test_saturate();
    idle_inputs();
    sat_mode = 1; load = 1; load_val = 4'd8; step();
    load = 0; en = 1; up_dn = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (tc !== model_tc(9, m_q)) begin
        n_bad++; $display("FAIL sat_tc got %b want %b", tc, model_tc(9, m_q));
      end
      step();
      n_cmp++;
      if (q !== 4'(m_q) || wrap !== 1'(m_w) || sat !== 1'(m_s)) begin
        n_bad++;
        $display("FAIL sat_q got q=%0d w=%b s=%b want q=%0d w=%0d s=%0d",
                 q, wrap, sat, m_q, m_w, m_s);
      end
    end
    n_cmp++;
    if (q !== 4'd9 || sat !== 1'b1) begin
      n_bad++; $display("FAIL sat_hold got q=%0d s=%b want q=9 s=1", q, sat);
    end
    clr = 1; step(); clr = 0;
    n_cmp++;
    if (q !== 4'd0 || sat !== 1'b0) begin
      n_bad++; $display("FAIL sat_clr got q=%0d s=%b want q=0 s=0", q, sat);
    end
  endtask

  task automatic test_load_clamp();
    idle_inputs();
    load = 1; load_val = 4'd13; en = 1; up_dn = 1; step();
    load = 0;
    n_cmp++;
    if (q !== 4'd9) begin n_bad++; $display("FAIL clamp_q got %0d want 9", q); end
    step();
    n_cmp++;
    if (q !== 4'd0 || wrap !== 1'b1) begin
      n_bad++; $display("FAIL clamp_wrap got q=%0d w=%b want q=0 w=1", q, wrap);
    end
    n_cmp++;
    if (q16 !== 4'(m16_q)) begin
      n_bad++; $display("FAIL clamp_m16 got %0d want %0d", q16, m16_q);
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    load = 1; load_val = 4'd5; step();
    load = 0; en = 1; up_dn = 1;
    rst = 1; load = 1; load_val = 4'd7; step();
    rst = 0; load = 0;
    n_cmp++;
    if (q !== 4'd0 || wrap !== 1'b0 || sat !== 1'b0) begin
      n_bad++; $display("FAIL midrst got q=%0d w=%b s=%b want 0 0 0", q, wrap, sat);
    end
    step(); step();
    n_cmp++;
    if (q !== 4'd2) begin n_bad++; $display("FAIL midrst_resume got %0d want 2", q); end
  endtask

  task automatic test_cascade();
    idle_inputs();
    rst = 1; step(); step();
    rst = 0; c_en = 1;
    for (int i = 1; i <= 105; i++) begin
      step();
      n_cmp++;
      if (int'(hi_q) * 10 + int'(lo_q) != c_cnt) begin
        n_bad++; $display("FAIL cascade_cycle%0d got %0d%0d want %0d", i, hi_q, lo_q, c_cnt);
      end
      if (i == 5 || i == 10 || i == 105) begin
        n_cmp++;
        if ({hi_q, lo_q} !== ((i == 10) ? 8'h10 : 8'h05)) begin
          n_bad++; $display("FAIL cascade_at%0d got %0d%0d", i, hi_q, lo_q);
        end
      end
    end
    c_en = 0;
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom);
      sat_mode = ($urandom_range(0, 3) == 0);
      #1;
      n_cmp++;
      if (tc !== model_tc(9, m_q) || tc16 !== model_tc(15, m16_q)) begin
        n_bad++;
        $display("FAIL rand_tc cyc%0d got %b/%b want %b/%b", i, tc, tc16,
                 model_tc(9, m_q), model_tc(15, m16_q));
      end
      step();
      n_cmp++;
      if (q !== 4'(m_q) || wrap !== 1'(m_w) || sat !== 1'(m_s)) begin
        n_bad++;
        $display("FAIL rand_m10 cyc%0d got q=%0d w=%b s=%b want q=%0d w=%0d s=%0d",
                 i, q, wrap, sat, m_q, m_w, m_s);
      end
      n_cmp++;
      if (q16 !== 4'(m16_q) || wrap16 !== 1'(m16_w) || sat16 !== 1'(m16_s)) begin
        n_bad++;
        $display("FAIL rand_m16 cyc%0d got q=%0d w=%b s=%b want q=%0d w=%0d s=%0d",
                 i, q16, wrap16, sat16, m16_q, m16_w, m16_s);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_clamp();
    test_mid_reset();
    test_cascade();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised synchronous up/down modulo counter. Next generation of the team's ripple T-flip-flop counters.
- All state is on one clock. It adds direction control, enable, synchronous load/clear, programmable modulus, wrap or saturate mode, and cascade/terminal-count outputs.
- Used as the general-purpose counter for timers, dividers and address generation. Several instances chain through tc/en.

Parameters:
- WIDTH, 4, counter register width in bits.
- MODULUS, 16, count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; any other value is an elaboration error.

Ports:
- clk  input  1  sole clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  0 = wrap at limits, 1 = saturate at limits.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational), used for cascading.
- wrap_pulse  output  1  registered one-cycle pulse on wrap.
- sat_hit  output  1  registered sticky flag: a count was blocked at a limit.

Behaviour:
- MAX = MODULUS-1. All actions evaluate on the rising edge of clk.
- Priority, highest first: rst > clr > load > en. Lower-priority actions are ignored in a cycle where a higher one is active.
- rst = 1:
  - q <= 0, wrap_pulse <= 0, sat_hit <= 0.
  - Takes effect at the next edge regardless of other inputs, including mid-count.
- clr = 1:
  - q <= 0, wrap_pulse <= 0, sat_hit <= 0.
- load = 1:
  - q <= load_val if load_val <= MAX, otherwise q <= MAX (clamp).
  - wrap_pulse <= 0, sat_hit <= 0.
  - en is ignored in this cycle.
- en = 1, up_dn = 1:
  - q < MAX: q <= q+1.
  - q == MAX, sat_mode = 0: q <= 0, wrap_pulse <= 1.
  - q == MAX, sat_mode = 1: q holds, sat_hit <= 1.
- en = 1, up_dn = 0:
  - q > 0: q <= q-1.
  - q == 0, sat_mode = 0: q <= MAX, wrap_pulse <= 1.
  - q == 0, sat_mode = 1: q holds, sat_hit <= 1.
- en = 0: q holds.
- wrap_pulse:
  - Is 0 in every cycle except the one immediately after a wrap.
  - It is high in the same cycle the wrapped q value is visible.
- sat_hit stays set until rst, clr or load.
- tc = en & ((up_dn & q==MAX) | (~up_dn & q==0)).
  - It asserts in both modes.
  - It is purely combinational from q/en/up_dn, with zero latency.
  - Cascade: a downstream counter's en is driven by the upstream tc, giving a synchronous multi-digit count.
- Direction changes take effect on the same edge, with no dead cycle.
- Latency: 1 clock from an input change to q.
- q never leaves 0..MAX, including when MODULUS < 2**WIDTH. Out-of-range codes are unreachable.
- With MODULUS = 2**WIDTH, the wrap is natural binary overflow, and behaviour is identical to the rules above.

Test Plan:
- WIDTH=4, MODULUS=10, rst for 2 cycles, then en=1, up_dn=1, sat_mode=0 for 12 cycles:
  - q = 0,1,...,9,0,1.
  - tc high only while q=9.
  - wrap_pulse high exactly in the cycle q returns to 0.
- Same configuration, down from q=2 (via load=1, load_val=2), en=1, up_dn=0:
  - q = 2,1,0,9,8.
  - tc high at q=0.
  - wrap_pulse high with q=9.
- sat_mode=1, load 8, count up 4 cycles:
  - q = 8,9,9,9.
  - sat_hit rises the cycle after the first blocked count and stays 1.
  - wrap_pulse stays 0.
  - A clr then gives q=0, sat_hit=0.
- load=1 with load_val=13 (> MAX=9), en=1 in the same cycle:
  - q = 9, with en ignored in that cycle.
  - Next up count wraps to 0.
- Mid-count rst (q=5, en=1) together with load=1:
  - Next cycle q=0, all flags 0.
  - Counting resumes from 0 after rst drops.
- Two cascaded instances (MODULUS=10), low tc driving high en, 105 enabled cycles from reset:
  - {high,low} = {0,5} after 5 cycles, {1,0} after 10, {0,5} after 105 (overall wrap at 100).
